// File: rtl/add_slice_sched.sv
// add_slice_sched: round-robin scheduler running two requesters' W-bit adds through one shared SLICE_W adder
module add_slice_sched #(
    parameter int SLICE_W  = 16,
    parameter int N_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [SLICE_W*N_SLICES-1:0]   req0_a,
    input  logic [SLICE_W*N_SLICES-1:0]   req0_b,
    input  logic                          req0_cin,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [SLICE_W*N_SLICES-1:0]   req1_a,
    input  logic [SLICE_W*N_SLICES-1:0]   req1_b,
    input  logic                          req1_cin,
    output logic [SLICE_W-1:0]            slice_a,
    output logic [SLICE_W-1:0]            slice_b,
    output logic                          slice_cin,
    input  logic [SLICE_W-1:0]            slice_sum,
    input  logic                          slice_cout,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [SLICE_W*N_SLICES-1:0]   resp_sum,
    output logic                          resp_cout,
    output logic                          resp_id
);
    localparam int W  = SLICE_W * N_SLICES;
    localparam int KW = N_SLICES > 1 ? $clog2(N_SLICES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        r_state;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_a, r_b, r_sum;
    logic          r_carry, r_id, r_last;
    logic          w_any, w_gnt, w_run, w_idle;
    // Operands shift down one slice per RUN cycle so the low slice is always the one in flight;
    // r_last remembers the previous winner so a tie goes to the other requester.
    always_comb begin
        w_idle     = r_state == IDLE;
        w_run      = r_state == RUN;
        w_any      = req0_valid | req1_valid;
        w_gnt      = (req0_valid & req1_valid) ? ~r_last : req1_valid;
        req0_ready = w_idle & req0_valid & ~w_gnt;
        req1_ready = w_idle & req1_valid & w_gnt;
        slice_a    = w_run ? r_a[SLICE_W-1:0] : '0;
        slice_b    = w_run ? r_b[SLICE_W-1:0] : '0;
        slice_cin  = w_run & r_carry;
        resp_valid = r_state == DONE;
        resp_sum   = r_sum;
        resp_cout  = r_carry;
        resp_id    = r_id;
    end
    // Scheduler FSM: capture the winner, walk the slices low to high, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_a     <= w_gnt ? req1_a : req0_a;
                    r_b     <= w_gnt ? req1_b : req0_b;
                    r_carry <= w_gnt ? req1_cin : req0_cin;
                    r_id    <= w_gnt;
                    r_last  <= w_gnt;
                    r_k     <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_sum   <= W'({slice_sum, r_sum} >> SLICE_W);
                    r_carry <= slice_cout;
                    r_k     <= r_k + 1'b1;
                    if (r_k == KW'(N_SLICES - 1)) r_state <= DONE;
                end
                DONE: if (resp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_slice_sched.sv
// tb_add_slice_sched: directed and randomised checks of add_slice_sched with a behavioural shared adder
module tb_add_slice_sched;
    logic        clk, rst;
    logic        req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
    logic [63:0] req0_a, req0_b, req1_a, req1_b, resp_sum;
    logic [15:0] slice_a, slice_b, slice_sum;
    logic        slice_cin, slice_cout, resp_valid, resp_ready, resp_cout, resp_id;
    int          total = 0, bad = 0;

    add_slice_sched #(.SLICE_W(16), .N_SLICES(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_sum(slice_sum), .slice_cout(slice_cout),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum),
        .resp_cout(resp_cout), .resp_id(resp_id)
    );

    // Behavioural shared adder the scheduler drives
    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + 17'(slice_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges from the accept edge until resp_valid, bounded
    task automatic wait_resp(input string tag, input int exp_n);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        chk(tag, 66'(n), 66'(exp_n));
    endtask

    function automatic logic [63:0] rnd64();
        return ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
    endfunction

    initial begin
        logic [65:0] q[$];
        logic [64:0] e;
        logic        g0, g1, seen;
        int          ops, resps, cyc, w;
        rst = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 66'(resp_valid), 66'(0));
        chk("rst_resp", {resp_id, resp_cout, resp_sum}, 66'(0));
        chk("rst_slice", {slice_cin, slice_a, slice_b}, 66'(0));
        rst = 1'b0;

        // Full carry ripple through every slice
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_cin = 1'b0;
        #1 chk("acc0_ready", {req1_ready, req0_ready}, 66'b01);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        chk("acc0_slice0", {slice_cin, slice_a, slice_b}, {1'b0, 16'hFFFF, 16'h0001});
        wait_resp("acc0_latency", 5);
        chk("acc0_resp", {resp_id, resp_cout, resp_sum}, {1'b0, 1'b1, 64'h0});

        // Back-pressure in DONE with both requesters knocking
        req0_valid = 1'b1; req1_valid = 1'b1; req1_a = 64'h55; req1_b = 64'h66;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_resp", {resp_valid, resp_id, resp_cout, resp_sum}, {1'b1, 1'b0, 1'b1, 64'h0});
            chk("hold_ready", {req1_ready, req0_ready}, 66'b00);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_xfer", 66'(resp_valid), 66'(0));
        resp_ready = 1'b0;
        @(negedge clk);
        chk("hold_nodup", 66'(resp_valid), 66'(0));

        // Carry crossing from slice 0 into slice 1 on requester 1
        req1_valid = 1'b1; req1_a = 64'h0000_0000_0000_FFFF; req1_b = 64'h0; req1_cin = 1'b1;
        #1 chk("acc1_ready", {req1_ready, req0_ready}, 66'b10);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_resp("acc1_latency", 5);
        chk("acc1_resp", {resp_id, resp_cout, resp_sum}, {1'b1, 1'b0, 64'h0000_0000_0001_0000});
        resp_ready = 1'b1;
        @(negedge clk);

        // Round-robin with both valid continuously from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd1;  req0_b = 64'd2;  req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 64'd10; req1_b = 64'd20; req1_cin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            w = 0;
            while (!(req0_ready | req1_ready) && w < 20) begin
                @(negedge clk);
                #1 w++;
            end
            chk("rr_grant", {req1_ready, req0_ready}, (i % 2) ? 66'b10 : 66'b01);
            @(posedge clk);
            wait_resp("rr_latency", 5);
            chk("rr_resp", {resp_id, resp_cout, resp_sum}, (i % 2) ? {1'b1, 1'b0, 64'd31} : {1'b0, 1'b0, 64'd3});
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Reset mid-operation at slice 2
        req0_valid = 1'b1; req0_a = 64'h1234_5678_9ABC_DEF0; req0_b = 64'h0; req0_cin = 1'b0;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("abort_k2", 66'(slice_a), 66'h5678);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_idle", {resp_valid, slice_cin, slice_a}, 66'(0));
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= resp_valid;
        end
        chk("abort_noresp", 66'(seen), 66'(0));
        req0_valid = 1'b1; req0_a = 64'h8000_0000_0000_0000; req0_b = 64'h8000_0000_0000_0001; req0_cin = 1'b1;
        #1 chk("abort_regrant", {req1_ready, req0_ready}, 66'b01);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_resp("abort_latency", 5);
        chk("abort_resp", {resp_id, resp_cout, resp_sum}, {1'b0, 1'b1, 64'h2});
        @(negedge clk);

        // Random traffic against the a+b+cin scoreboard
        ops = 0; resps = 0; cyc = 0;
        while (cyc < 40000 && !(ops >= 1000 && q.size() == 0 && !resp_valid && !req0_valid && !req1_valid)) begin
            @(negedge clk);
            cyc++;
            if (!req0_valid && ops < 1000 && $urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1; req0_a = rnd64(); req0_b = rnd64(); req0_cin = 1'($urandom_range(0, 1));
            end else if (req0_valid && $urandom_range(0, 7) == 0) req0_valid = 1'b0;
            if (!req1_valid && ops < 1000 && $urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1; req1_a = rnd64(); req1_b = rnd64(); req1_cin = 1'($urandom_range(0, 1));
            end else if (req1_valid && $urandom_range(0, 7) == 0) req1_valid = 1'b0;
            resp_ready = $urandom_range(0, 2) != 0;
            #1;
            g0 = req0_ready; g1 = req1_ready;
            if (g0) begin
                e = {1'b0, req0_a} + {1'b0, req0_b} + 65'(req0_cin);
                q.push_back({1'b0, e});
                ops++;
            end
            if (g1) begin
                e = {1'b0, req1_a} + {1'b0, req1_b} + 65'(req1_cin);
                q.push_back({1'b1, e});
                ops++;
            end
            if (resp_valid && resp_ready) begin
                resps++;
                if (q.size() == 0) chk("rnd_dup", 66'(0), 66'(1));
                else chk("rnd_resp", {resp_id, resp_cout, resp_sum}, q.pop_front());
            end
            @(posedge clk);
            #1;
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
        end
        chk("rnd_timeout", 66'(cyc < 40000), 66'(1));
        chk("rnd_count", 66'(resps), 66'(ops));
        chk("rnd_drained", 66'(q.size()), 66'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add_slice_sched.md
ADD_SLICE_SCHED -- requirements
Module: add_slice_sched

Interface
REQ-001 Parameter SLICE_W, default 16, width of the shared adder slice.
REQ-002 Parameter N_SLICES, default 4, slices per operand; operand width W = SLICE_W*N_SLICES (64).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-006 reqN_ready  output  1  requester N operation accepted this cycle.
REQ-007 reqN_a, reqN_b  input  W  requester N operands.
REQ-008 reqN_cin  input  1  requester N carry-in.
REQ-009 slice_a, slice_b  output  SLICE_W  operand slice driven to the shared external adder.
REQ-010 slice_cin  output  1  carry into the shared adder.
REQ-011 slice_sum  input  SLICE_W  combinational sum returned by the shared adder.
REQ-012 slice_cout  input  1  combinational carry-out returned by the shared adder.
REQ-013 resp_valid  output  1  result available.
REQ-014 resp_ready  input  1  consumer accepts result.
REQ-015 resp_sum  output  W  full sum.
REQ-016 resp_cout  output  1  final carry-out.
REQ-017 resp_id  output  1  index of the requester owning the result.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 IDLE: if any reqN_valid, grant exactly one requester, assert its reqN_ready combinationally that cycle, capture its a, b, cin and id, clear slice index k, go RUN.
REQ-020 Arbitration round-robin: a single valid request wins; if both valid, the one not granted last wins; pointer after reset favours req0.
REQ-021 reqN_ready SHALL be 0 in RUN and DONE and for the non-granted requester.
REQ-022 RUN cycle k: slice_a = a[k*SLICE_W +: SLICE_W], slice_b likewise, slice_cin = captured cin when k=0 else registered carry.
REQ-023 RUN cycle k: register slice_sum into result bits [k*SLICE_W +: SLICE_W]; register slice_cout as carry; k increments.
REQ-024 After k = N_SLICES-1, go DONE; resp_cout = carry from the last slice; resp_sum = concatenated slices, mod 2^W.
REQ-025 slice_a, slice_b, slice_cin SHALL be 0 outside RUN.
REQ-026 DONE: resp_valid = 1; resp_sum, resp_cout, resp_id held stable until resp_ready = 1; on resp_valid & resp_ready go IDLE next cycle.
REQ-027 Latency: accept at cycle T, resp_valid first high at T+N_SLICES+1 (T+5 at defaults); max throughput one operation per N_SLICES+2 cycles.
REQ-028 Request inputs SHALL be ignored outside IDLE; a requester deasserting valid before grant has no effect.
REQ-029 resp_valid SHALL be 0 in IDLE and RUN.

Reset
REQ-030 rst SHALL force state IDLE, k = 0, carry = 0, resp_valid = 0, resp_sum = 0, resp_cout = 0, resp_id = 0, RR pointer to favour req0.
REQ-031 rst asserted in RUN or DONE SHALL abort the operation; no response is produced for it.
REQ-032 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-033 req0 a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> resp_sum=0, resp_cout=1, resp_id=0, resp_valid 5 cycles after accept.
REQ-034 req1 a=0x0000_0000_0000_FFFF, b=0, cin=1 -> resp_sum=0x0000_0000_0001_0000, resp_cout=0 (carry crosses slice boundary).
REQ-035 both valid continuously after reset -> grants req0, req1, req0, req1; resp_id sequence 0,1,0,1.
REQ-036 resp_ready low for 3 cycles in DONE -> resp_* stable, both reqN_ready low, one transfer on ready.
REQ-037 rst pulsed at RUN k=2 -> next cycle IDLE, resp_valid 0, no response; subsequent request completes correctly.
REQ-038 1000 random operations, random valids and resp_ready -> every result equals a+b+cin reference model, no lost or duplicated response.
